instruction_decode: RTL
=======================

# instruction_decode

Decode stage of the non-pipelined RV32I core, directly downstream of instruction fetch. Consumes the fetched instruction word and its PC, decodes RV32I control fields, reads two operands from the integer register file it owns, and generates the sign-extended immediate. It accepts the write-back port from the final stage. All results are registered and presented to execute one cycle later.

## Interface
- XLEN, 32, data/address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_in  in  32  instruction from fetch
- pc_in  in  XLEN  PC of instr_in
- wb_en  in  1  register write-back enable
- wb_rd  in  5  write-back destination index
- wb_data  in  XLEN  write-back value
- pc_out  out  XLEN  registered pc_in
- rs1_data, rs2_data  out  XLEN  operand values
- imm  out  XLEN  sign-extended immediate
- rd  out  5  destination index
- funct3  out  3  instr[14:12], for branch/load/store width
- alu_op  out  4  ALU operation, encoding in package
- alu_src_imm  out  1  ALU B operand = imm
- alu_src_pc  out  1  ALU A operand = PC (AUIPC, JAL, branch target)
- reg_write, mem_read, mem_write, branch, jump  out  1  control flags
- illegal  out  1  unsupported/malformed instruction

## Operation
- Register file: 32 x XLEN. x0 reads 0; writes to x0 are ignored. Write on posedge when wb_en=1.
- Read bypass: if wb_en && wb_rd==rsN && rsN!=0, rsN_data takes wb_data in the same cycle (write-first).
- Immediates: I, S, B, U, J formats, sign-extended from instr[31]. B/J have bit0=0. U = instr[31:12]<<12. R-type gives imm=0.
- alu_op: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- Decode by opcode:
  - LUI: PASS_B, imm src, reg_write.
  - AUIPC: ADD, pc+imm, reg_write.
  - JAL: jump, reg_write, pc+imm.
  - JALR: jump, reg_write, ADD rs1+imm. funct3 must be 000.
  - BRANCH: branch, SUB. funct3 010/011 illegal.
  - LOAD: mem_read, reg_write, ADD. funct3 011/110/111 illegal.
  - STORE: mem_write, ADD. funct3 >=011 illegal.
  - OP-IMM / OP: ALU ops from funct3/funct7.
    - funct7 must be 0000000, or 0100000 only for SUB/SRA/SRAI.
    - Shift-imm uses imm[4:0].
  - MISC-MEM (FENCE): NOP, all flags 0.
  - SYSTEM and all other opcodes, or instr[1:0]!=11: illegal.
- Illegal: illegal=1, all other control flags 0, rd=0.
- Bubble: instr_in==32'h0 (fetch reset value) decodes as NOP, all flags 0, illegal=0.

## Timing
- Latency 1 cycle: inputs sampled at posedge N, outputs valid after N, held until posedge N+1.
- Write-back commits at the same posedge that registers the decode of a reader. The bypass guarantees the reader sees the new value.
- Reset (any time, including mid-stream) asynchronously clears every output to 0 and all 32 registers to 0. The first post-reset instruction decodes normally on the first rising edge after rst falls.
- No stall/valid handshake: the stage advances every cycle, matching fetch.

## Structure
- Shared package rv32_pkg: opcode constants, alu_op enum/localparams, immediate-format enum, REG_ADDR_W=5.
- Sub-module register_file: 2 async read ports with bypass, 1 sync write port, x0 hardwired, async reset. Decode logic and output registers live in the top module.

## Test plan
- Reset with rst pulse mid-stream -> all outputs 0. Subsequent read of x5 -> rs1_data=0.
- wb x5=0xDEADBEEF, then instr 0xFFF28313 (addi x6,x5,-1) -> rs1_data=0xDEADBEEF, imm=0xFFFFFFFF, rd=6, alu_op=ADD, alu_src_imm=1, reg_write=1.
- Same cycle: wb x7=0x00001234 and instr 0x00038433 (add x8,x7,x0) -> rs1_data=0x1234, rs2_data=0, alu_op=ADD.
- wb x0=0xFFFFFFFF, then read x0 -> 0. wb_en with wb_rd=0 does not bypass.
- Immediate formats:
  - 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, alu_op=SUB, funct3=0.
  - 0x123451B7 (lui x3,0x12345) -> imm=0x12345000, alu_op=PASS_B.
- Edge decodes:
  - 0xFFFFFFFF -> illegal=1, reg_write=0.
  - 0x00000000 -> illegal=0, all flags 0.
  - 0x40001033 (funct7=0100000 with SLL) -> illegal=1.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I definitions for the decode stage.
//   - XLEN / REG_ADDR_W widths
//   - base opcode constants and funct7 values
//   - alu_op_t encoding consumed by execute
//   - imm_fmt_t immediate formats and the gen_imm helper
//   - ctrl_t bundle of per-instruction control flags
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SHAMT,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src_imm;
        logic    alu_src_pc;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, default: 1'b0};

    // Sign bit is always instr[31]; B and J immediates have an implicit bit0 of 0.
    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [XLEN-1:0] v;
        case (fmt)
            IMM_I:     v = {{20{instr[31]}}, instr[31:20]};
            IMM_SHAMT: v = {27'b0, instr[24:20]};
            IMM_S:     v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     v = {instr[31:12], 12'b0};
            IMM_J:     v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   v = '0;
        endcase
        return v;
    endfunction

    // funct3 -> ALU op for OP / OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file: 32 x XLEN integer register file.
//   clk, rst          clock, asynchronous active-high reset (clears all registers)
//   rs1_addr/rs2_addr read indices; rs1_data/rs2_data combinational read data
//   wb_en, wb_rd,     synchronous write port, committed on the rising edge
//   wb_data
// x0 always reads zero and ignores writes. A read of the register being
// written this cycle returns wb_data (write-first bypass).
module register_file
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data
);

    logic [XLEN-1:0] regs [1:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
        logic [XLEN-1:0] v;
        if (addr == '0) begin
            v = '0;
        end else if (wb_en && (wb_rd == addr)) begin
            v = wb_data;
        end else begin
            v = regs[addr];
        end
        return v;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: RV32I decode stage of the non-pipelined core.
//   clk, rst             clock, asynchronous active-high reset
//   instr_in, pc_in      fetched instruction and its PC
//   wb_en, wb_rd,        write-back port from the final stage
//   wb_data
//   pc_out               registered pc_in
//   rs1_data, rs2_data   register operands (bypassed from write-back)
//   imm                  sign-extended immediate
//   rd, funct3           destination index, instr[14:12]
//   alu_op, alu_src_imm, ALU control
//   alu_src_pc
//   reg_write, mem_read, control flags
//   mem_write, branch,
//   jump, illegal
// Interface timing: there is no valid/ready handshake; the stage accepts a new
// instruction on every rising edge and presents its decode until the next one.
// A zero instruction word is the fetch bubble and decodes as a NOP.
module instruction_decode
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       pc_out,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       imm,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [2:0]            funct3,
    output logic [3:0]            alu_op,
    output logic                  alu_src_imm,
    output logic                  alu_src_pc,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  illegal
);

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    ctrl_t                 ctrl;
    imm_fmt_t              fmt;
    logic                  bad;
    logic                  alt;
    logic [REG_ADDR_W-1:0] rd_next;

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign f7     = instr_in[31:25];

    register_file u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (instr_in[19:15]),
        .rs2_addr (instr_in[24:20]),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    always_comb begin
        ctrl = CTRL_NOP;
        fmt  = IMM_NONE;
        bad  = 1'b0;
        alt  = 1'b0;
        if (instr_in == 32'h0) begin
            // fetch bubble: NOP with no flags
        end else if (instr_in[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    fmt              = IMM_U;
                    ctrl.alu_op      = ALU_PASS_B;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.reg_write   = 1'b1;
                end
                OPC_AUIPC: begin
                    fmt              = IMM_U;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.alu_src_pc  = 1'b1;
                    ctrl.reg_write   = 1'b1;
                end
                OPC_JAL: begin
                    fmt              = IMM_J;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.alu_src_pc  = 1'b1;
                    ctrl.reg_write   = 1'b1;
                    ctrl.jump        = 1'b1;
                end
                OPC_JALR: begin
                    fmt              = IMM_I;
                    bad              = (f3 != 3'b000);
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.reg_write   = 1'b1;
                    ctrl.jump        = 1'b1;
                end
                OPC_BRANCH: begin
                    // The ALU compares rs1 - rs2; the PC-relative target uses
                    // imm and pc_out directly, so the ALU sources stay on registers.
                    fmt         = IMM_B;
                    bad         = (f3 == 3'b010) || (f3 == 3'b011);
                    ctrl.alu_op = ALU_SUB;
                    ctrl.branch = 1'b1;
                end
                OPC_LOAD: begin
                    fmt              = IMM_I;
                    bad              = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.reg_write   = 1'b1;
                    ctrl.mem_read    = 1'b1;
                end
                OPC_STORE: begin
                    fmt              = IMM_S;
                    bad              = (f3 >= 3'b011);
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.mem_write   = 1'b1;
                end
                OPC_OP_IMM: begin
                    // Only the shift forms carry a funct7; elsewhere those bits are immediate.
                    if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                        fmt = IMM_SHAMT;
                        alt = (f3 == 3'b101) && (f7 == F7_ALT);
                        bad = !((f7 == F7_BASE) || alt);
                    end else begin
                        fmt = IMM_I;
                    end
                    ctrl.alu_op      = alu_from_funct3(f3, alt);
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.reg_write   = 1'b1;
                end
                OPC_OP: begin
                    alt            = (f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101));
                    bad            = !((f7 == F7_BASE) || alt);
                    ctrl.alu_op    = alu_from_funct3(f3, alt);
                    ctrl.reg_write = 1'b1;
                end
                OPC_MISC_MEM: begin
                    fmt = IMM_I;
                end
                default: begin
                    bad = 1'b1;
                end
            endcase
        end

        if (bad) begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
            fmt          = IMM_NONE;
        end
        rd_next = bad ? '0 : instr_in[11:7];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out      <= '0;
            rs1_data    <= '0;
            rs2_data    <= '0;
            imm         <= '0;
            rd          <= '0;
            funct3      <= '0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            alu_src_pc  <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            pc_out      <= pc_in;
            rs1_data    <= rs1_val;
            rs2_data    <= rs2_val;
            imm         <= gen_imm(instr_in, fmt);
            rd          <= rd_next;
            funct3      <= f3;
            alu_op      <= ctrl.alu_op;
            alu_src_imm <= ctrl.alu_src_imm;
            alu_src_pc  <= ctrl.alu_src_pc;
            reg_write   <= ctrl.reg_write;
            mem_read    <= ctrl.mem_read;
            mem_write   <= ctrl.mem_write;
            branch      <= ctrl.branch;
            jump        <= ctrl.jump;
            illegal     <= ctrl.illegal;
        end
    end

endmodule
